// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: synchronises and deglitches the pins,
// decodes start/8 data/odd parity/stop frames and strobes good or bad results.
module ps2_rx_frame #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 10000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_c,
    input  logic       ps2_d,
    input  logic       rx_en,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       rx_error,
    output logic       rx_busy
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    function automatic logic odd_parity_ok(input logic [7:0] data_b, input logic par_b);
        return ^{data_b, par_b};
    endfunction

    state_t                state_r, state_n;
    logic [1:0]            c_sync_r, d_sync_r;
    logic [FILTER_LEN-1:0] filt_r;
    logic                  filt_level_r, fall_edge_r;
    logic [TW-1:0]         tmo_cnt_r;
    logic [2:0]            bit_cnt_r;
    logic [7:0]            shift_r;
    logic                  parity_r;
    logic                  d_bit_s, tmo_hit_s;
    logic                  start_s, shift_s, par_cap_s, done_s, err_s;

    assign d_bit_s = d_sync_r[1];
    // Abort on the cycle the idle counter would step onto TIMEOUT-1.
    assign tmo_hit_s = (tmo_cnt_r == TW'(TIMEOUT - 2));

    // Two-flop synchronisers for both pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_sync_r <= 2'b11;
            d_sync_r <= 2'b11;
        end else begin
            c_sync_r <= {c_sync_r[0], ps2_c};
            d_sync_r <= {d_sync_r[0], ps2_d};
        end
    end

    // Clock deglitch filter and registered falling-edge detect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_r       <= {FILTER_LEN{1'b1}};
            filt_level_r <= 1'b1;
            fall_edge_r  <= 1'b0;
        end else begin
            filt_r      <= {filt_r[FILTER_LEN-2:0], c_sync_r[1]};
            fall_edge_r <= filt_level_r && (filt_r == {FILTER_LEN{1'b0}});
            if (filt_r == {FILTER_LEN{1'b0}}) begin
                filt_level_r <= 1'b0;
            end else if (filt_r == {FILTER_LEN{1'b1}}) begin
                filt_level_r <= 1'b1;
            end else begin
                filt_level_r <= filt_level_r;
            end
        end
    end

    // Frame FSM next-state and strobe decode.
    always_comb begin
        state_n   = state_r;
        start_s   = 1'b0;
        shift_s   = 1'b0;
        par_cap_s = 1'b0;
        done_s    = 1'b0;
        err_s     = 1'b0;
        if (!rx_en) begin
            state_n = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (fall_edge_r && !d_bit_s) begin
                        state_n = DATA;
                        start_s = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
                DATA: begin
                    if (fall_edge_r) begin
                        shift_s = 1'b1;
                        state_n = (bit_cnt_r == 3'd7) ? PARITY : DATA;
                    end else if (tmo_hit_s) begin
                        state_n = IDLE;
                        err_s   = 1'b1;
                    end else begin
                        state_n = DATA;
                    end
                end
                PARITY: begin
                    if (fall_edge_r) begin
                        par_cap_s = 1'b1;
                        state_n   = STOP;
                    end else if (tmo_hit_s) begin
                        state_n = IDLE;
                        err_s   = 1'b1;
                    end else begin
                        state_n = PARITY;
                    end
                end
                STOP: begin
                    if (fall_edge_r) begin
                        state_n = IDLE;
                        if (d_bit_s && odd_parity_ok(shift_r, parity_r)) begin
                            done_s = 1'b1;
                        end else begin
                            err_s = 1'b1;
                        end
                    end else if (tmo_hit_s) begin
                        state_n = IDLE;
                        err_s   = 1'b1;
                    end else begin
                        state_n = STOP;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // FSM state, frame datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            tmo_cnt_r <= {TW{1'b0}};
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'h00;
            parity_r  <= 1'b0;
            rx_data   <= 8'h00;
            rx_done   <= 1'b0;
            rx_error  <= 1'b0;
        end else begin
            state_r <= state_n;
            if ((state_r == IDLE) || fall_edge_r) begin
                tmo_cnt_r <= {TW{1'b0}};
            end else begin
                tmo_cnt_r <= tmo_cnt_r + TW'(1);
            end
            if (start_s) begin
                bit_cnt_r <= 3'd0;
            end else if (shift_s) begin
                bit_cnt_r <= bit_cnt_r + 3'd1;
            end else begin
                bit_cnt_r <= bit_cnt_r;
            end
            if (shift_s) begin
                shift_r <= {d_bit_s, shift_r[7:1]};
            end else begin
                shift_r <= shift_r;
            end
            if (par_cap_s) begin
                parity_r <= d_bit_s;
            end else begin
                parity_r <= parity_r;
            end
            if (done_s) begin
                rx_data <= shift_r;
            end else begin
                rx_data <= rx_data;
            end
            rx_done  <= done_s;
            rx_error <= err_s;
        end
    end

    assign rx_busy = (state_r != IDLE);

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Directed bench for ps2_rx_frame: a PS/2 device model sends frames and the
// bench checks strobes, data, latency, timeout, glitch rejection and resets.
module tb_ps2_rx_frame;

    localparam int FL   = 8;
    localparam int TMO  = 10000;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_c = 1'b1;
    logic       ps2_d = 1'b1;
    logic       rx_en = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done, rx_error, rx_busy;

    int total = 0, bad = 0;
    int cyc = 0, fall_cyc = 0;
    int done_hi = 0, err_hi = 0, both_hi = 0;
    int last_done_cyc = 0, last_err_cyc = 0;
    int d0, e0;

    ps2_rx_frame #(.FILTER_LEN(FL), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .ps2_c(ps2_c), .ps2_d(ps2_d), .rx_en(rx_en),
        .rx_data(rx_data), .rx_done(rx_done), .rx_error(rx_error), .rx_busy(rx_busy)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor, sampled on the falling clock edge.
    always @(negedge clk) begin
        if (rx_done) begin
            done_hi       <= done_hi + 1;
            last_done_cyc <= cyc;
        end
        if (rx_error) begin
            err_hi       <= err_hi + 1;
            last_err_cyc <= cyc;
        end
        if (rx_done && rx_error) both_hi <= both_hi + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ps2_bit(input logic b, input logic glitch);
        ps2_d = b;
        if (glitch) begin
            tick(7);
            ps2_c = 1'b0;
            tick(5);
            ps2_c = 1'b1;
            tick(8);
        end else begin
            tick(HALF);
        end
        ps2_c    = 1'b0;
        fall_cyc = cyc;
        tick(HALF);
        ps2_c = 1'b1;
    endtask

    task automatic send(input logic [7:0] b, input logic par, input logic stp, input logic [10:0] gmask);
        logic [10:0] fr;
        fr = {stp, par, b, 1'b0};
        for (int i = 0; i < 11; i++) ps2_bit(fr[i], gmask[i]);
        ps2_d = 1'b1;
        tick(3 * HALF);
    endtask

    initial begin
        logic [10:0] fr;
        tick(3);
        chk("rst_data", {24'h0, rx_data}, 32'h0);
        chk("rst_done", {31'h0, rx_done}, 32'h0);
        chk("rst_err",  {31'h0, rx_error}, 32'h0);
        chk("rst_busy", {31'h0, rx_busy}, 32'h0);
        rst = 1'b0;
        tick(20);

        // ACK byte
        d0 = done_hi; e0 = err_hi;
        send(8'hFA, 1'b1, 1'b1, 11'h0);
        chk("fa_done", done_hi - d0, 32'd1);
        chk("fa_err",  err_hi - e0, 32'd0);
        chk("fa_data", {24'h0, rx_data}, 32'hFA);
        chk("fa_lat",  last_done_cyc - fall_cyc, 32'(FL + 4));

        // Bad parity
        d0 = done_hi; e0 = err_hi;
        send(8'h55, 1'b0, 1'b1, 11'h0);
        chk("par_err",  err_hi - e0, 32'd1);
        chk("par_done", done_hi - d0, 32'd0);
        chk("par_data", {24'h0, rx_data}, 32'hFA);
        chk("par_lat",  last_err_cyc - fall_cyc, 32'(FL + 4));

        // Bad stop, then a good frame
        d0 = done_hi; e0 = err_hi;
        send(8'hAA, 1'b1, 1'b0, 11'h0);
        chk("stop_err", err_hi - e0, 32'd1);
        chk("stop_done", done_hi - d0, 32'd0);
        d0 = done_hi; e0 = err_hi;
        send(8'h1C, 1'b0, 1'b1, 11'h0);
        chk("1c_done", done_hi - d0, 32'd1);
        chk("1c_err",  err_hi - e0, 32'd0);
        chk("1c_data", {24'h0, rx_data}, 32'h1C);

        // Stalled frame: start + 4 data bits, clock then held high
        e0 = err_hi;
        fr = {1'b1, 1'b1, 8'h06, 1'b0};
        for (int i = 0; i < 5; i++) ps2_bit(fr[i], 1'b0);
        chk("tmo_busy_mid", {31'h0, rx_busy}, 32'd1);
        for (int k = 0; (k < TMO + 100) && (err_hi == e0); k++) tick(1);
        chk("tmo_err",  err_hi - e0, 32'd1);
        chk("tmo_lat",  last_err_cyc - fall_cyc, 32'(FL + 3 + TMO));
        chk("tmo_busy", {31'h0, rx_busy}, 32'd0);
        ps2_d = 1'b1;
        tick(HALF);
        d0 = done_hi;
        send(8'h29, 1'b0, 1'b1, 11'h0);
        chk("29_done", done_hi - d0, 32'd1);
        chk("29_data", {24'h0, rx_data}, 32'h29);

        // Short clock glitches in idle (with data low) and mid-frame
        d0 = done_hi; e0 = err_hi;
        ps2_d = 1'b0;
        tick(10);
        ps2_c = 1'b0;
        tick(5);
        ps2_c = 1'b1;
        tick(20);
        chk("gl_idle_busy", {31'h0, rx_busy}, 32'd0);
        ps2_d = 1'b1;
        tick(10);
        send(8'h5A, 1'b1, 1'b1, 11'b000_1000_1010);
        chk("gl_done", done_hi - d0, 32'd1);
        chk("gl_err",  err_hi - e0, 32'd0);
        chk("gl_data", {24'h0, rx_data}, 32'h5A);

        // Receive disabled for a whole frame
        d0 = done_hi; e0 = err_hi;
        rx_en = 1'b0;
        send(8'hFA, 1'b1, 1'b1, 11'h0);
        rx_en = 1'b1;
        chk("dis_done", done_hi - d0, 32'd0);
        chk("dis_err",  err_hi - e0, 32'd0);
        chk("dis_data", {24'h0, rx_data}, 32'h5A);

        // Reset after 6 data bits, then a fresh frame
        d0 = done_hi; e0 = err_hi;
        fr = {1'b1, 1'b1, 8'h3C, 1'b0};
        for (int i = 0; i < 7; i++) ps2_bit(fr[i], 1'b0);
        chk("mr_busy_pre", {31'h0, rx_busy}, 32'd1);
        rst = 1'b1;
        #2;
        chk("mr_data", {24'h0, rx_data}, 32'h0);
        chk("mr_busy", {31'h0, rx_busy}, 32'd0);
        chk("mr_strb", {30'h0, rx_done, rx_error}, 32'd0);
        tick(3);
        rst   = 1'b0;
        ps2_d = 1'b1;
        tick(40);
        chk("mr_nostrobe", (done_hi - d0) + (err_hi - e0), 32'd0);
        send(8'hF0, 1'b1, 1'b1, 11'h0);
        chk("f0_done", done_hi - d0, 32'd1);
        chk("f0_err",  err_hi - e0, 32'd0);
        chk("f0_data", {24'h0, rx_data}, 32'hF0);

        // Strobe widths across the run: 5 good frames, 3 failures
        chk("done_cycles", done_hi, 32'd5);
        chk("err_cycles",  err_hi, 32'd3);
        chk("both_high",   both_hi, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
